// File: rtl/pixel_mem_pkg.sv
// Shared geometry and addressing for the 1-bit-per-pixel image memory
// (8 pixels per byte, bit 0 holds the lowest x in the byte).
package pixel_mem_pkg;

  localparam int IMG_WIDTH     = 640;
  localparam int IMG_HEIGHT    = 480;
  localparam int BYTES_PER_ROW = IMG_WIDTH / 8;
  localparam int PIX_ADDR_W    = 16;

  typedef logic [PIX_ADDR_W-1:0] pix_addr_t;
  typedef logic [9:0]            coord_t;

  // Row-major byte address; computed at 17 bits so out-of-range inputs wrap predictably.
  function automatic pix_addr_t pix_byte_addr(input coord_t x, input coord_t y,
                                              input int bytes_per_row = BYTES_PER_ROW);
    logic [16:0] a;
    a = 17'(y) * 17'(bytes_per_row) + 17'(x >> 3);
    return a[PIX_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_read_arbiter_if.sv
// Requester-side bundle: level requests with packed coordinates,
// one-hot ack and tagged one-cycle responses.
interface pixel_read_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*10-1:0] x;
  logic [NREQ*10-1:0] y;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    resp_valid;
  logic               resp_pixel;
  logic               resp_oob;

  modport master (
    output req, x, y,
    input  ack, resp_valid, resp_pixel, resp_oob
  );

  modport slave (
    input  req, x, y,
    output ack, resp_valid, resp_pixel, resp_oob
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating priority
// pointer that advances past the last winner.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Search starts at the pointer and wraps; the first requester found wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (!found && en && !reset && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_read_arbiter.sv
// Shares the image memory read port among NREQ pixel requesters; every grant
// becomes a tagged pixel response exactly three cycles later.
module pixel_read_arbiter
  import pixel_mem_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int NREQ   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  pixel_read_arbiter_if.slave  rq,
  output pix_addr_t            rdaddress,
  input  logic [7:0]           rdata
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BPR  = WIDTH / 8;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            grant_any;
  coord_t          x_sel;
  coord_t          y_sel;
  logic            oob_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .req    (rq.req),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign rq.ack    = gnt;
  assign grant_any = |gnt;

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        x_sel = rq.x[i*10 +: 10];
        y_sel = rq.y[i*10 +: 10];
      end
    end
  end

  assign oob_sel = (int'(x_sel) >= WIDTH) || (int'(y_sel) >= HEIGHT);

  logic            vld_p0, vld_p1;
  logic [ID_W-1:0] id_p0, id_p1;
  logic [2:0]      bit_p0, bit_p1;
  logic            oob_p0, oob_p1;
  logic [NREQ-1:0] resp_valid_q;
  logic            resp_pixel_q;
  logic            resp_oob_q;

  // Stage A: capture the grant and issue the byte address (held on out-of-range).
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      rdaddress <= '0;
    end else begin
      vld_p0 <= grant_any;
      if (grant_any && !oob_sel) begin
        rdaddress <= pix_byte_addr(x_sel, y_sel, BPR);
      end
    end
  end

  always_ff @(posedge clk) begin
    id_p0  <= gnt_id;
    bit_p0 <= x_sel[2:0];
    oob_p0 <= oob_sel;
  end

  // Stage B: memory samples rdaddress; tag travels alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    id_p1  <= id_p0;
    bit_p1 <= bit_p0;
    oob_p1 <= oob_p0;
  end

  // Stage C: rdata valid; select the bit and strobe the owning requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_pixel_q <= 1'b0;
      resp_oob_q   <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (vld_p1) begin
        resp_valid_q[id_p1] <= 1'b1;
        resp_pixel_q        <= oob_p1 ? 1'b0 : rdata[bit_p1];
        resp_oob_q          <= oob_p1;
      end
    end
  end

  assign rq.resp_valid = resp_valid_q;
  assign rq.resp_pixel = resp_pixel_q;
  assign rq.resp_oob   = resp_oob_q;

endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Cycle-by-cycle directed vectors for pixel_read_arbiter against a byte memory
// model with one-cycle synchronous read.
module tb_pixel_read_arbiter;
  import pixel_mem_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      en;
  logic [7:0] rdata;
  pix_addr_t rdaddress;

  pixel_read_arbiter_if #(.NREQ(4)) rq ();

  pixel_read_arbiter #(.WIDTH(640), .HEIGHT(480), .NREQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rq        (rq),
    .rdaddress (rdaddress),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) rdata <= mem[rdaddress];

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [39:0] x;
    logic [39:0] y;
    logic [3:0]  ack;
    logic [3:0]  rv;
    logic        chk;
    logic        pix;
    logic        oob;
    logic        chka;
    logic [15:0] addr;
  } vec_t;

  vec_t        tbl[$];
  logic [39:0] cur_x, cur_y;
  int          n_cmp = 0;
  int          n_bad = 0;

  int b2b_x [4] = '{8, 9, 1, 5};
  int b2b_y [4] = '{0, 0, 1, 2};
  int b2b_p [4] = '{1, 0, 1, 0};

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic setc(input int i, input int xx, input int yy);
    cur_x[i*10 +: 10] = 10'(xx);
    cur_y[i*10 +: 10] = 10'(yy);
  endtask

  task automatic row(input logic r, input logic e, input logic [3:0] rqv, input logic [3:0] ak,
                     input logic [3:0] rv, input logic c, input logic p, input logic o,
                     input logic ca, input int ad);
    vec_t v;
    v.rst = r; v.en = e; v.req = rqv; v.x = cur_x; v.y = cur_y;
    v.ack = ak; v.rv = rv; v.chk = c; v.pix = p; v.oob = o;
    v.chka = ca; v.addr = 16'(ad);
    tbl.push_back(v);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[1]   = 8'h01;
    mem[80]  = 8'h02;
    mem[161] = 8'h10;

    cur_x = '0; cur_y = '0;
    //   rst en req     ack     rv      chk pix oob chka addr
    // single reads (8,0) -> 1 and (9,0) -> 0
    setc(0, 8, 0);  row(0, 1, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 1, 0);
    setc(0, 9, 0);  row(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0001, 1, 1, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    // contention from reset release
    setc(0, 1, 1); setc(1, 12, 2); setc(2, 0, 0); setc(3, 5, 2);
    row(1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b1111, 4'b0001, 4'b0000, 1, 0, 0, 1, 0);
    row(0, 1, 4'b1110, 4'b0010, 4'b0000, 0, 0, 0, 1, 80);
    row(0, 1, 4'b1100, 4'b0100, 4'b0000, 0, 0, 0, 1, 161);
    row(0, 1, 4'b1000, 4'b1000, 4'b0001, 1, 1, 0, 1, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 1, 160);
    row(0, 1, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b1000, 1, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    // fairness: req0 always re-requesting, req2 held
    setc(0, 8, 0); setc(2, 9, 0);
    row(0, 1, 4'b0101, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    setc(0, 1, 1);  row(0, 1, 4'b0101, 4'b0100, 4'b0000, 0, 0, 0, 0, 0);
    setc(2, 12, 2); row(0, 1, 4'b0101, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    setc(0, 0, 0);  row(0, 1, 4'b0101, 4'b0100, 4'b0001, 1, 1, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0001, 1, 1, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0100, 1, 1, 0, 0, 0);
    // out of range after an in-range read leaves rdaddress=1 (byte 0x01)
    setc(1, 8, 0);   row(0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 1, 161);
    setc(1, 640, 0); row(0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 1, 1);
    setc(1, 0, 480); row(0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 0, 1, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 0, 1, 1, 1);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    // enable gating with two lookups in flight and req3 pending
    setc(0, 8, 0); setc(1, 1, 1);
    row(0, 1, 4'b0011, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
    setc(3, 12, 2);
    row(0, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 0, 4'b1000, 4'b0000, 4'b0001, 1, 1, 0, 0, 0);
    row(0, 0, 4'b1000, 4'b0000, 4'b0010, 1, 1, 0, 0, 0);
    row(0, 1, 4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b1000, 1, 1, 0, 0, 0);
    // reset one cycle after ack0 discards the lookup and rewinds the pointer
    setc(0, 8, 0);  row(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 1, 161);
    setc(2, 1, 1);  row(1, 1, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    setc(0, 12, 2); row(0, 1, 4'b0101, 4'b0001, 4'b0000, 1, 0, 0, 1, 0);
    row(0, 1, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 1, 161);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0001, 1, 1, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0100, 1, 1, 0, 0, 0);
    row(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    reset = 1'b1; en = 1'b1; rq.req = '0; rq.x = '0; rq.y = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset  = tbl[i].rst;
      en     = tbl[i].en;
      rq.req = tbl[i].req;
      rq.x   = tbl[i].x;
      rq.y   = tbl[i].y;
      #1;
      chk("ack", i, 32'(rq.ack), 32'(tbl[i].ack));
      chk("resp_valid", i, 32'(rq.resp_valid), 32'(tbl[i].rv));
      if (tbl[i].chk) begin
        chk("resp_pixel", i, 32'(rq.resp_pixel), 32'(tbl[i].pix));
        chk("resp_oob", i, 32'(rq.resp_oob), 32'(tbl[i].oob));
      end
      if (tbl[i].chka) chk("rdaddress", i, 32'(rdaddress), 32'(tbl[i].addr));
    end

    // back-to-back grants to one requester: responses on consecutive cycles
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      if (c < 4) begin
        rq.req        = 4'b1000;
        rq.x[39:30]   = 10'(b2b_x[c]);
        rq.y[39:30]   = 10'(b2b_y[c]);
      end else begin
        rq.req = 4'b0000;
      end
      #1;
      chk("b2b_ack", 100 + c, 32'(rq.ack), (c < 4) ? 32'h8 : 32'h0);
      if (c >= 3 && c < 7) begin
        chk("b2b_resp_valid", 100 + c, 32'(rq.resp_valid), 32'h8);
        chk("b2b_resp_pixel", 100 + c, 32'(rq.resp_pixel), 32'(b2b_p[c-3]));
      end else begin
        chk("b2b_resp_valid", 100 + c, 32'(rq.resp_valid), 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
